regfile_sb: RTL

Parametrised successor to the CPU's 8×16 register file: configurable width and depth, two bypassed read ports, one write-back port, a per-register pending scoreboard for hazard detection, and a sequenced clear engine. It sits between decode (reads, issue marking) and write-back in the pipelined core. Decode stalls on the `*_pend` outputs and on `clr_busy`.

---
 rtl/regfile_sb_if.sv | 29 ++
 rtl/regfile_sb.sv | 102 ++++++++++
 2 files changed

// File: rtl/regfile_sb_if.sv
// Decode/write-back bus of the scoreboarded register file.
interface regfile_sb_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
);
  logic [AW-1:0] ra_addr;
  logic [AW-1:0] rb_addr;
  logic [DW-1:0] ra_data;
  logic [DW-1:0] rb_data;
  logic          ra_pend;
  logic          rb_pend;
  logic          iss_valid;
  logic [AW-1:0] iss_addr;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          clr_req;
  logic          clr_busy;

  modport master (
    output ra_addr, rb_addr, iss_valid, iss_addr, wb_valid, wb_addr, wb_data, clr_req,
    input  ra_data, rb_data, ra_pend, rb_pend, clr_busy
  );

  modport slave (
    input  ra_addr, rb_addr, iss_valid, iss_addr, wb_valid, wb_addr, wb_data, clr_req,
    output ra_data, rb_data, ra_pend, rb_pend, clr_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two bypassed read ports, write-back port, pending
// scoreboard and a sequenced (or one-shot) clear engine.
module regfile_sb #(
  parameter int unsigned DW          = 16,
  parameter int unsigned AW          = 3,
  parameter bit          ZERO_REG    = 1'b1,
  parameter bit          CLR_ONESHOT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  localparam int unsigned NREG = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic [DW-1:0] rf [NREG];
  logic [NREG-1:0] sb;

  logic idle;
  logic wb_eff;
  logic iss_eff;
  logic ra_hit;
  logic rb_hit;
  logic ra_zero;
  logic rb_zero;

  // Effective write/issue qualification; clear engine blocks both.
  assign idle    = (state == IDLE);
  assign wb_eff  = idle && bus.wb_valid && !(ZERO_REG && (bus.wb_addr == '0));
  assign iss_eff = idle && bus.iss_valid && !(ZERO_REG && (bus.iss_addr == '0));
  assign ra_hit  = wb_eff && (bus.wb_addr == bus.ra_addr);
  assign rb_hit  = wb_eff && (bus.wb_addr == bus.rb_addr);
  assign ra_zero = ZERO_REG && (bus.ra_addr == '0);
  assign rb_zero = ZERO_REG && (bus.rb_addr == '0);

  // Clear FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Clear FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clr_req) state_nxt = CLR_ONESHOT ? DONE : WALK;
      WALK:    if (cnt == LAST) state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read ports: bypass the write-back, mask r0, stall decode while clearing.
  always_comb begin
    bus.ra_data  = '0;
    bus.rb_data  = '0;
    bus.ra_pend  = 1'b1;
    bus.rb_pend  = 1'b1;
    bus.clr_busy = 1'b1;
    if (idle) begin
      bus.clr_busy = 1'b0;
      bus.ra_pend  = sb[bus.ra_addr] & ~ra_hit;
      bus.rb_pend  = sb[bus.rb_addr] & ~rb_hit;
      if (ra_hit)        bus.ra_data = bus.wb_data;
      else if (!ra_zero) bus.ra_data = rf[bus.ra_addr];
      if (rb_hit)        bus.rb_data = bus.wb_data;
      else if (!rb_zero) bus.rb_data = rf[bus.rb_addr];
    end
  end

  // Array, scoreboard and walk counter; issue set wins over write-back clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
      sb  <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (bus.clr_req && CLR_ONESHOT) begin
        for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
        sb <= '0;
      end else begin
        if (wb_eff) begin
          rf[bus.wb_addr] <= bus.wb_data;
          sb[bus.wb_addr] <= 1'b0;
        end
        if (iss_eff) sb[bus.iss_addr] <= 1'b1;
        if (bus.clr_req) cnt <= '0;
      end
    end else if (state == WALK) begin
      rf[cnt] <= '0;
      sb[cnt] <= 1'b0;
      if (cnt != LAST) cnt <= cnt + AW'(1);
    end
  end

endmodule
